// File: rtl/lcd_hd44780_sequencer.sv
// HD44780 write sequencer: turns a rising edge on the config PIO request bit into
// one full LCD bus write (setup, E pulse, hold, execution wait) with busy/done/overrun status.
module lcd_hd44780_sequencer #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 82000,
    parameter int CNT_W   = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] config_in,
    input  logic [7:0] data_in,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(T_LONG - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic             req_q, req_edge;
    logic             long_q, long_next;
    logic             en_next, rs_next, busy_next, done_next, overrun_next;
    logic [7:0]       data_next;

    assign req_edge = config_in[1] & ~req_q;
    assign lcd_rw   = 1'b0;

    // req_q resets high so a request level held through reset release is not taken as an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            req_q    <= 1'b1;
            long_q   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            counter  <= counter_next;
            req_q    <= config_in[1];
            long_q   <= long_next;
            lcd_en   <= en_next;
            lcd_rs   <= rs_next;
            lcd_data <= data_next;
            busy     <= busy_next;
            done     <= done_next;
            overrun  <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        long_next    = long_q;
        en_next      = lcd_en;
        rs_next      = lcd_rs;
        data_next    = lcd_data;
        busy_next    = busy;
        done_next    = 1'b0;
        overrun_next = req_edge && (state != IDLE);

        case (state)
            IDLE: begin
                if (req_edge) begin
                    rs_next      = config_in[0];
                    data_next    = data_in;
                    long_next    = !config_in[0] && (data_in == 8'h01 || data_in == 8'h02);
                    busy_next    = 1'b1;
                    counter_next = SETUP_LOAD;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                if (counter == '0) begin
                    en_next      = 1'b1;
                    counter_next = EN_LOAD;
                    state_next   = PULSE;
                end else begin
                    counter_next = counter - 1'b1;
                end
            end
            PULSE: begin
                if (counter == '0) begin
                    en_next      = 1'b0;
                    counter_next = HOLD_LOAD;
                    state_next   = HOLD;
                end else begin
                    counter_next = counter - 1'b1;
                end
            end
            HOLD: begin
                if (counter == '0) begin
                    counter_next = long_q ? LONG_LOAD : EXEC_LOAD;
                    state_next   = WAIT;
                end else begin
                    counter_next = counter - 1'b1;
                end
            end
            WAIT: begin
                if (counter == '0) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    counter_next = counter - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_hd44780_sequencer.sv
// Bench for lcd_hd44780_sequencer: directed scenarios plus random request traffic,
// every cycle compared against a transaction-age model of the LCD write sequence.
module tb_lcd_hd44780_sequencer;

    localparam int T_SETUP = 2;
    localparam int T_EN    = 4;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 10;
    localparam int T_LONG  = 30;
    localparam int CNT_W   = 17;
    localparam int SHORT_TOTAL = T_SETUP + T_EN + T_HOLD + T_EXEC;
    localparam int LONG_TOTAL  = T_SETUP + T_EN + T_HOLD + T_LONG;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] config_in;
    logic [7:0] data_in;
    logic       lcd_en, lcd_rs, lcd_rw, busy, done, overrun;
    logic [7:0] lcd_data;

    int compared   = 0;
    int mismatched = 0;

    // Model: a write is described only by its age in clock edges since acceptance
    bit         m_has;
    int         m_age, m_total;
    logic       m_rs, m_ov, m_prev_req;
    logic [7:0] m_data;

    lcd_hd44780_sequencer #(
        .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_LONG(T_LONG), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .config_in(config_in), .data_in(data_in),
        .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [13:0] dutVec();
        return {lcd_en, lcd_rs, lcd_rw, lcd_data, busy, done, overrun};
    endfunction

    function automatic logic [13:0] modelVec();
        logic en_e, busy_e, done_e;
        en_e   = m_has && m_age >= T_SETUP && m_age < T_SETUP + T_EN;
        busy_e = m_has && m_age < m_total;
        done_e = m_has && m_age == m_total;
        return {en_e, m_rs, 1'b0, m_data, busy_e, done_e, m_ov};
    endfunction

    task automatic modelReset();
        m_has = 0; m_age = 0; m_total = 0;
        m_rs = 1'b0; m_data = 8'h00; m_ov = 1'b0; m_prev_req = 1'b1;
    endtask

    task automatic modelEdge(input logic [1:0] cfg, input logic [7:0] din);
        logic req_rise, active;
        req_rise   = cfg[1] && !m_prev_req;
        m_prev_req = cfg[1];
        active     = m_has && m_age < m_total;
        m_ov       = req_rise && active;
        if (req_rise && !active) begin
            m_has   = 1;
            m_age   = 0;
            m_rs    = cfg[0];
            m_data  = din;
            m_total = T_SETUP + T_EN + T_HOLD +
                      ((!cfg[0] && (din == 8'h01 || din == 8'h02)) ? T_LONG : T_EXEC);
        end else if (m_has && m_age <= m_total) begin
            m_age++;
        end
    endtask

    // Drive at a falling edge, let one rising edge happen, then compare at the next falling edge
    task automatic applyStimulus(input logic [1:0] cfg, input logic [7:0] din);
        config_in = cfg;
        data_in   = din;
        modelEdge(cfg, din);
        @(posedge clk);
        @(negedge clk);
        checkOutput("cycle", 32'(dutVec()), 32'(modelVec()));
    endtask

    task automatic doReset(input logic [1:0] cfg);
        reset     = 1'b1;
        config_in = cfg;
        modelReset();
        #1;
        checkOutput("async_reset", 32'(dutVec()), 32'(modelVec()));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // mode 0: plain write, 1: second request mid-pulse, 2: back-to-back on done, 3: reset during pulse
    task automatic runWrite(input logic rs, input logic [7:0] d, input int mode,
                            input int exp_busy, input string tag);
        int   busy_cnt, en_cnt, en_first, ov_cnt, done_cnt;
        logic req;
        logic [7:0] dd;
        logic [1:0] cfg;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            applyStimulus({1'b0, rs}, d);
        end
        applyStimulus({1'b0, rs}, d);
        applyStimulus({1'b1, rs}, d);
        busy_cnt = 0; en_cnt = 0; en_first = -1; ov_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) busy_cnt++;
            if (lcd_en) begin
                if (en_first < 0) en_first = i;
                en_cnt++;
            end
            ov_cnt   += int'(overrun);
            done_cnt += int'(done);
            if (!busy) break;
            if (mode == 3 && i == T_SETUP + 1) begin
                reset = 1'b1;
                #1;
                checkOutput({tag, "_en_after_reset"}, 32'(lcd_en), 32'd0);
                checkOutput({tag, "_busy_after_reset"}, 32'(busy), 32'd0);
                modelReset();
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            req = 1'b1;
            dd  = 8'($urandom);
            cfg = {1'b1, 1'($urandom)};
            if (mode == 1) begin
                req = !(i == 1 || i == 2);
                dd  = (i == 3) ? 8'h55 : d;
                cfg = {req, rs};
            end else if (mode == 2) begin
                cfg = {1'b0, rs};
            end
            applyStimulus(cfg, dd);
        end
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        checkOutput({tag, "_en_start"}, 32'(en_first), 32'(T_SETUP));
        checkOutput({tag, "_en_cycles"}, 32'(en_cnt), 32'(T_EN));
        checkOutput({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, "_overruns"}, 32'(ov_cnt), (mode == 1) ? 32'd1 : 32'd0);
        checkOutput({tag, "_rs"}, 32'(lcd_rs), 32'(rs));
        checkOutput({tag, "_data"}, 32'(lcd_data), 32'(d));
        if (mode == 2) begin
            applyStimulus({1'b1, rs}, 8'h33);
            checkOutput({tag, "_rebusy"}, 32'(busy), 32'd1);
            checkOutput({tag, "_new_data"}, 32'(lcd_data), 32'h33);
        end
    endtask

    initial begin
        logic       req, rs;
        logic [7:0] d;

        reset     = 1'b1;
        config_in = 2'b10;
        data_in   = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 32'(dutVec()), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(2'b10, 8'h41);
        checkOutput("held_req_no_write", 32'(busy), 32'd0);

        runWrite(1'b1, 8'h41, 0, SHORT_TOTAL, "data_write");
        runWrite(1'b0, 8'h01, 0, LONG_TOTAL, "clear_cmd");
        runWrite(1'b0, 8'h02, 0, LONG_TOTAL, "home_cmd");
        runWrite(1'b1, 8'h01, 0, SHORT_TOTAL, "data_01");
        runWrite(1'b0, 8'h38, 0, SHORT_TOTAL, "normal_cmd");
        runWrite(1'b1, 8'h41, 1, SHORT_TOTAL, "overrun");
        runWrite(1'b1, 8'h41, 2, SHORT_TOTAL, "back_to_back");
        runWrite(1'b1, 8'h41, 3, SHORT_TOTAL, "reset_pulse");

        req = 1'b0;
        rs  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                doReset({1'($urandom), 1'($urandom)});
                req = config_in[1];
            end
            if ($urandom_range(0, 5) == 0) req = ~req;
            if ($urandom_range(0, 3) == 0) rs = ~rs;
            case ($urandom_range(0, 3))
                0:       d = 8'h01;
                1:       d = 8'h02;
                default: d = 8'($urandom);
            endcase
            applyStimulus({req, rs}, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
